div_ctrl: RTL and testbench
===========================

// Module: div_ctrl
// PURPOSE
//  Sequencer for the multi-cycle DIV/DIVU unit in the execute stage.
//  Accepts one divide request from the decoded instruction, runs a radix-2
//  restoring division for WIDTH iterations, and holds the pipeline stalled
//  until the result is ready. Returns HI (remainder) and LO (quotient) for
//  the hi/lo register write. Supports cancellation by pipeline flush.
// PARAMETERS
//  WIDTH   32   operand width; quotient and remainder are each WIDTH bits
// PORTS
//  clk         in   1        system clock, rising edge
//  resetn      in   1        asynchronous active-low reset
//  start       in   1        E-stage holds DIV/DIVU; sampled only in IDLE
//  signed_div  in   1        1 = DIV (two's complement), 0 = DIVU
//  opa         in   WIDTH    dividend (rs)
//  opb         in   WIDTH    divisor (rt)
//  flush       in   1        annul in-flight divide (exception/eret)
//  stall_o     out  1        hold pipeline stages F..E
//  busy        out  1        FSM not in IDLE
//  valid_o     out  1        one-cycle pulse: result is valid
//  result      out  2*WIDTH  {HI=remainder, LO=quotient}
// BEHAVIOUR
//  - Clock and reset: one clock, clk. Reset is asynchronous and
//    active-low on resetn.
//  - Reset: state=IDLE; stall_o, busy and valid_o = 0; result = 0;
//    counter and internal registers = 0.
//  - FSM states: IDLE -> PREP -> CALC -> DONE -> IDLE.
//  - IDLE
//    - start=1 and flush=0: latch opa, opb and signed_div; go to PREP.
//  - PREP
//    - Convert the latched operands to magnitudes (signed mode only).
//    - Record sa = opa MSB and sb = opb MSB; clear the partial remainder.
//    - Load count = WIDTH - 1; go to CALC.
//  - CALC
//    - Each cycle: shift {rem,quo} left 1 and trial-subtract |opb|.
//      A non-negative difference is kept and shifts in quotient bit 1.
//    - Then decrement count; count == 0 goes to DONE.
//  - DONE
//    - valid_o = 1 for exactly this cycle; the result register is loaded
//      the same cycle; go to IDLE.
//    - Sign fix-up (signed mode): quotient is negated if sa^sb; remainder
//      is negated if sa (the remainder takes the dividend's sign).
//  - result holds its value until the next DONE.
//  - Latency: start high in cycle 0 -> valid_o in cycle WIDTH+2
//    (cycle 34 at WIDTH=32).
//  - stall_o = (IDLE & start & ~flush) | PREP | CALC. It is 0 in DONE, so
//    the divide instruction advances in the same cycle as valid_o.
//  - start in the DONE cycle is ignored. The next divide is sampled in
//    IDLE on the following cycle (back-to-back issue, no lost request).
//  - busy = (state != IDLE).
//  - flush in any state: next state is IDLE and valid_o stays 0; result
//    is unchanged. flush takes priority over start in IDLE.
//  - Operand changes while busy are ignored (operands are latched).
//  - Overflow case: signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000,
//    HI=0. This falls out of magnitude arithmetic with wrap.
//  - resetn low mid-operation: immediate return to the reset values; no
//    valid pulse.
// CONFIGURATION
//  DIV_ZERO_FAST_EN
//    - Defined: in PREP, opb==0 skips CALC and goes directly to DONE.
//      valid_o appears in cycle 2; result = {HI=opa, LO=all ones} for
//      both signed and unsigned.
//    - Undefined: divide-by-zero runs the full WIDTH iterations. It gives
//      the natural restoring result: unsigned {HI=opa, LO=all ones};
//      signed gets the same sign fix-up as any other divide.
// TESTING
//  1. DIVU 100/7 -> valid_o cycle 34; LO=14, HI=2; stall_o high cycles
//     0..33, low in cycle 34.
//  2. DIV 0xFFFFFFF9/2 (-7/2) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//     DIV 7/0xFFFFFFFE -> LO=0xFFFFFFFD, HI=1.
//  3. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
//  4. flush pulse in cycle 10 of a divide -> IDLE in cycle 11; no
//     valid_o; stall_o low. A new DIVU 9/3 then gives LO=3, HI=0.
//  5. Back-to-back: 20/3 followed immediately by 21/4 -> two valid_o
//     pulses 35 cycles apart; results {2,6} then {1,5}.
//  6. DIVU 5/0 -> {HI=5, LO=0xFFFFFFFF}: cycle 2 with DIV_ZERO_FAST_EN,
//     cycle 34 without. Also resetn low mid-CALC -> all outputs 0
//     asynchronously.

Source files
------------

// File: rtl/div_ctrl_if.sv
// Request/response bundle between the execute stage and the divide sequencer.
// Master drives the request side (start, operands, flush).
// Slave returns the stall, busy, valid and result signals.
interface div_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 start;
  logic                 signed_div;
  logic [WIDTH-1:0]     opa;
  logic [WIDTH-1:0]     opb;
  logic                 flush;
  logic                 stall_o;
  logic                 busy;
  logic                 valid_o;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output start, signed_div, opa, opb, flush,
    input  stall_o, busy, valid_o, result
  );

  modport slave (
    input  start, signed_div, opa, opb, flush,
    output stall_o, busy, valid_o, result
  );
endinterface

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer: radix-2 restoring division over WIDTH
// iterations, with the pipeline stalled while it runs.
// result = {HI = remainder, LO = quotient}.
// Optional feature macro: DIV_ZERO_FAST_EN. When it is defined, a zero
// divisor skips the iteration phase and returns {opa, all ones}.
module div_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input logic       clk,
  input logic       resetn,
  div_ctrl_if.slave bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state, state_nx;

  logic [WIDTH-1:0]     a_q, b_q;     // latched operands; b_q becomes |opb| in PREP
  logic                 sgn_q;        // latched signed_div
  logic                 sa, sb;       // operand signs (0 in unsigned mode)
  logic [WIDTH-1:0]     rem, quo;     // partial remainder / dividend-quotient shift pair
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   res_q;
`ifdef DIV_ZERO_FAST_EN
  logic                 zf;           // divisor was zero: bypass the iteration phase
`endif

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       partial;
  logic                 ge;
  logic [WIDTH-1:0]     rem_sub;
  logic [WIDTH-1:0]     q_fix, r_fix;
  logic [2*WIDTH-1:0]   res_fix;
  logic                 in_done;

  // Operand magnitudes, one restoring step, and final sign fix-up.
  always_comb begin
    a_mag   = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
    b_mag   = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
    partial = {rem, quo[WIDTH-1]};
    // The true difference is below 2^WIDTH whenever it is kept, so a
    // WIDTH-bit subtract of the low bits is exact.
    ge      = (partial >= {1'b0, b_q});
    rem_sub = partial[WIDTH-1:0] - b_q;
    q_fix   = (sa ^ sb) ? -quo : quo;
    r_fix   = sa ? -rem : rem;
    res_fix = {r_fix, q_fix};
`ifdef DIV_ZERO_FAST_EN
    if (zf) begin
      res_fix = {a_q, {WIDTH{1'b1}}};
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; flush returns to IDLE from any state.
  always_comb begin
    state_nx = state;
    if (bus.flush) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: if (bus.start) state_nx = PREP;
        PREP: begin
`ifdef DIV_ZERO_FAST_EN
          state_nx = (b_q == '0) ? DONE : CALC;
`else
          state_nx = CALC;
`endif
        end
        CALC: if (cnt == '0) state_nx = DONE;
        DONE: state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Datapath registers: operand latch, preparation, iteration, result load.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      rem   <= '0;
      quo   <= '0;
      cnt   <= '0;
      res_q <= '0;
`ifdef DIV_ZERO_FAST_EN
      zf    <= 1'b0;
`endif
    end else if (!bus.flush) begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_q   <= bus.opa;
            b_q   <= bus.opb;
            sgn_q <= bus.signed_div;
          end
        end
        PREP: begin
          sa  <= sgn_q & a_q[WIDTH-1];
          sb  <= sgn_q & b_q[WIDTH-1];
          rem <= '0;
          quo <= a_mag;
          b_q <= b_mag;
          cnt <= CW'(WIDTH - 1);
`ifdef DIV_ZERO_FAST_EN
          zf  <= (b_q == '0);
`endif
        end
        CALC: begin
          rem <= ge ? rem_sub : partial[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ge};
          cnt <= cnt - 1'b1;
        end
        DONE: begin
          res_q <= res_fix;
        end
        default: ;
      endcase
    end
  end

  // Outputs: the fixed-up result is forwarded during the valid cycle and
  // held in res_q afterwards.
  always_comb begin
    in_done        = (state == DONE);
    bus.busy       = (state != IDLE);
    bus.valid_o    = in_done && !bus.flush;
    bus.stall_o    = ((state == IDLE) && bus.start && !bus.flush)
                   || (state == PREP) || (state == CALC);
    bus.result     = bus.valid_o ? res_fix : res_q;
  end
endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed divides with a scoreboard of
// expected results and arrival cycles.
module tb_div_ctrl;
  localparam int unsigned W = 32;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 34;
`endif

  logic clk;
  logic resetn;
  int   cyc;
  int   ncmp;
  int   nerr;

  typedef struct {
    logic [63:0] res;
    int          at;
  } exp_t;
  exp_t sbq[$];
  logic [63:0] last_res;

  div_ctrl_if #(.WIDTH(W)) bus ();

  div_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (resetn === 1'b1 && bus.valid_o === 1'b1) begin
      ncmp++;
      assert (sbq.size() != 0) else begin
        nerr++;
        $error("FAIL unexpected_valid: observed result %h at cycle %0d expected no pulse",
               bus.result, cyc);
      end
      if (sbq.size() != 0) begin
        exp_t e;
        e = sbq.pop_front();
        check("result", bus.result, e.res);
        check("latency_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (sd) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic push(input logic [63:0] res, input int at);
    exp_t e;
    e.res = res;
    e.at  = at;
    sbq.push_back(e);
    last_res = res;
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ncmp++;
    assert (sbq.size() == 0) else begin
      nerr++;
      $error("FAIL %s_timeout: observed %0d pending expected 0", tag, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic do_div(input string tag, input logic sd, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int lat);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.signed_div = sd; bus.opa = a; bus.opb = b;
    push(exp, cyc + lat);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_empty(tag);
  endtask

  initial begin
    int c0;
    ncmp = 0; nerr = 0; cyc = 0; last_res = '0;
    resetn = 1'b0;
    bus.start = 1'b0; bus.signed_div = 1'b0; bus.opa = '0; bus.opb = '0; bus.flush = 1'b0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   64'(bus.busy),    64'd0);
    check("rst_stall",  64'(bus.stall_o), 64'd0);
    check("rst_valid",  64'(bus.valid_o), 64'd0);
    check("rst_result", bus.result,       64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // DIVU 100/7 with stall/busy profile; operands changed while busy.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.opa = 32'd100; bus.opb = 32'd7;
    c0 = cyc;
    push({32'd2, 32'd14}, c0 + 34);
    for (int i = 0; i <= 34; i++) begin
      @(negedge clk);
      check($sformatf("stall_c%0d", i), 64'(bus.stall_o), (i < 34) ? 64'd1 : 64'd0);
      check($sformatf("busy_c%0d", i),  64'(bus.busy),    (i != 0) ? 64'd1 : 64'd0);
      @(posedge clk); #1;
      if (i == 0) begin
        bus.start = 1'b0; bus.opa = 32'hDEAD_BEEF; bus.opb = 32'd3;
      end
    end
    wait_empty("divu_100_7");
    check("result_held", bus.result, {32'd2, 32'd14});

    // Signed cases, including overflow wrap.
    do_div("div_m7_2",  1'b1, 32'hFFFF_FFF9, 32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);
    do_div("div_7_m2",  1'b1, 32'd7,         32'hFFFF_FFFE, {32'd1,         32'hFFFF_FFFD}, 34);
    do_div("div_ovf",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0,         32'h8000_0000}, 34);

    // Flush in cycle 10 of a divide: no pulse, result unchanged.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.opa = 32'd1000; bus.opb = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_busy",   64'(bus.busy),    64'd0);
    check("flush_stall",  64'(bus.stall_o), 64'd0);
    check("flush_valid",  64'(bus.valid_o), 64'd0);
    check("flush_result", bus.result,       last_res);
    repeat (40) @(posedge clk);
    do_div("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34);

    // Back-to-back: start held high across DONE, second request in IDLE.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.opa = 32'd20; bus.opb = 32'd3;
    c0 = cyc;
    push({32'd2, 32'd6}, c0 + 34);
    push({32'd1, 32'd5}, c0 + 69);
    @(posedge clk); #1;
    bus.opa = 32'd21; bus.opb = 32'd4;
    repeat (35) @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_empty("back_to_back");

    // Divide by zero.
    do_div("divu_5_0", 1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, ZLAT);
`ifdef DIV_ZERO_FAST_EN
    do_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, ZLAT);
`else
    do_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'h0000_0001}, ZLAT);
`endif

    // A few model-checked divides (nonzero divisor, no overflow operands).
    for (int k = 0; k < 6; k++) begin
      logic [31:0] a, b;
      logic sd;
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 28);
      b  = (b == 32'd0) ? 32'd1 : b;
      sd = k[0];
      if (sd && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      do_div($sformatf("rand_%0d", k), sd, a, b, model(sd, a, b), 34);
    end

    // Asynchronous reset mid-iteration.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.opa = 32'd100; bus.opb = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_busy",   64'(bus.busy),    64'd0);
    check("arst_stall",  64'(bus.stall_o), 64'd0);
    check("arst_valid",  64'(bus.valid_o), 64'd0);
    check("arst_result", bus.result,       64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(posedge clk);
    do_div("post_reset", 1'b0, 32'd77, 32'd10, {32'd7, 32'd7}, 34);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
